// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the 10-bit pipelined CPU.
//   W        - datapath / PC / instruction width
//   RESET_PC - PC value loaded on reset
//   word_t   - one datapath word
package cpu_pkg;

    localparam int W = 10;

    typedef logic [W-1:0] word_t;

    localparam word_t RESET_PC = 10'h000;

endpackage : cpu_pkg

// File: rtl/pc_incrementer.sv
// pc_incrementer: W-bit ripple-free adder used as the PC incrementer.
// Ports:
//   a, b  - W-bit operands
//   cin   - carry in
//   sum   - W-bit result (wraps on overflow)
//   cout  - carry out of the top bit
module pc_incrementer
    import cpu_pkg::*;
#(
    parameter int W = cpu_pkg::W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    // Zero-extend both operands by one bit so the carry lands in the MSB.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule : pc_incrementer

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 10-bit pipelined CPU.
// Holds the PC, selects the next PC, drives the instruction-memory address
// and latches the fetched instruction + its PC into the IF/ID register.
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   j_cntrl           - next PC comes from the selected jump target
//   pc_en             - PC register loads next PC (else holds)
//   pc_hazard         - sequential path replays pc_out instead of pc+1
//   E, F              - jump-target source select (EX, then M, else IF)
//   cache_Ready       - IF register captures instruction and PC
//   LA_IF/LA_EX/LA_M  - jump targets from IF/decode, EX and M stages
//   imem_rdata        - combinational instruction memory read data
//   imem_addr         - current PC (instruction memory address)
//   instruction_out   - IF-register instruction
//   pc_out            - IF-register PC
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int           W        = cpu_pkg::W,
    parameter logic [W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         j_cntrl,
    input  logic         pc_en,
    input  logic         pc_hazard,
    input  logic         E,
    input  logic         F,
    input  logic         cache_Ready,
    input  logic [W-1:0] LA_IF,
    input  logic [W-1:0] LA_EX,
    input  logic [W-1:0] LA_M,
    input  logic [W-1:0] imem_rdata,
    output logic [W-1:0] imem_addr,
    output logic [W-1:0] instruction_out,
    output logic [W-1:0] pc_out
);

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic [W-1:0] instr;
        logic [W-1:0] pc;
    } if_reg_t;

    logic [W-1:0] pc;
    logic [W-1:0] pc_inc;
    logic [W-1:0] la;
    logic [W-1:0] seq;
    logic [W-1:0] next_pc;
    logic         pc_inc_cout_unused;
    if_reg_t      if_reg;

    // PC + 1; the carry is dropped so 3FF wraps to 000.
    pc_incrementer #(
        .W (W)
    ) u_pc_inc (
        .a    (pc),
        .b    ({{(W-1){1'b0}}, 1'b1}),
        .cin  (1'b0),
        .sum  (pc_inc),
        .cout (pc_inc_cout_unused)
    );

    // Later pipeline stages carry the more recent control decision, so EX
    // beats M beats IF when several targets are offered at once.
    always_comb begin
        la = LA_IF;
        if (E)
            la = LA_EX;
        else if (F)
            la = LA_M;
    end

    // A hazard replays the PC that was last captured into the IF register,
    // i.e. the instruction that must be fetched again.
    assign seq     = pc_hazard ? if_reg.pc : pc_inc;
    assign next_pc = j_cntrl ? la : seq;

    always_ff @(posedge clk) begin
        if (reset)
            pc <= RESET_PC;
        else if (pc_en)
            pc <= next_pc;
    end

    // Capture is independent of pc_en: a full stall needs both dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_reg.instr <= '0;
            if_reg.pc    <= RESET_PC;
        end else if (cache_Ready) begin
            if_reg.instr <= imem_rdata;
            if_reg.pc    <= pc;
        end
    end

    assign imem_addr       = pc;
    assign instruction_out = if_reg.instr;
    assign pc_out          = if_reg.pc;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage. Memory returns addr ^ 2AA.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic  clk;
    logic  reset, j_cntrl, pc_en, pc_hazard, E, F, cache_Ready;
    word_t LA_IF, LA_EX, LA_M, imem_rdata, imem_addr, instruction_out, pc_out;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .j_cntrl         (j_cntrl),
        .pc_en           (pc_en),
        .pc_hazard       (pc_hazard),
        .E               (E),
        .F               (F),
        .cache_Ready     (cache_Ready),
        .LA_IF           (LA_IF),
        .LA_EX           (LA_EX),
        .LA_M            (LA_M),
        .imem_rdata      (imem_rdata),
        .imem_addr       (imem_addr),
        .instruction_out (instruction_out),
        .pc_out          (pc_out)
    );

    assign imem_rdata = imem_addr ^ 10'h2AA;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ctl = {reset, j_cntrl, pc_en, pc_hazard, E, F, cache_Ready}
    typedef struct {
        string      name;
        logic [6:0] ctl;
        word_t      la_if, la_ex, la_m;
        word_t      exp_addr, exp_ins, exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic [6:0] c, word_t lif, word_t lex,
                                word_t lm, word_t ea, word_t ei, word_t ep);
        vec_t v;
        v.name = n; v.ctl = c; v.la_if = lif; v.la_ex = lex; v.la_m = lm;
        v.exp_addr = ea; v.exp_ins = ei; v.exp_pc = ep;
        return v;
    endfunction

    task automatic chk(string n, word_t act, word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(logic [6:0] c, word_t lif, word_t lex, word_t lm);
        {reset, j_cntrl, pc_en, pc_hazard, E, F, cache_Ready} = c;
        LA_IF = lif; LA_EX = lex; LA_M = lm;
    endtask

    // Apply inputs, take one edge, compare all outputs 1 time unit later.
    task automatic step_chk(string n, logic [6:0] c, word_t lif, word_t lex, word_t lm,
                            word_t ea, word_t ei, word_t ep);
        drive(c, lif, lex, lm);
        @(posedge clk);
        #1;
        chk({n, ".addr"}, imem_addr, ea);
        chk({n, ".ins"},  instruction_out, ei);
        chk({n, ".pc"},   pc_out, ep);
    endtask

    initial begin
        drive(7'b1010001, '0, '0, '0);

        //              name      rst j en hz E F cr   LA_IF   LA_EX   LA_M    addr    ins     pc_out
        vecs.push_back(mk("rst",    7'b1_0_1_0_0_0_1, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000));
        vecs.push_back(mk("seq1",   7'b0_0_1_0_0_0_1, 10'h000, 10'h000, 10'h000, 10'h001, 10'h2AA, 10'h000));
        vecs.push_back(mk("seq2",   7'b0_0_1_0_0_0_1, 10'h000, 10'h000, 10'h000, 10'h002, 10'h2AB, 10'h001));
        vecs.push_back(mk("seq3",   7'b0_0_1_0_0_0_1, 10'h000, 10'h000, 10'h000, 10'h003, 10'h2A8, 10'h002));
        vecs.push_back(mk("seq4",   7'b0_0_1_0_0_0_1, 10'h000, 10'h000, 10'h000, 10'h004, 10'h2A9, 10'h003));
        vecs.push_back(mk("seq5",   7'b0_0_1_0_0_0_1, 10'h000, 10'h000, 10'h000, 10'h005, 10'h2AE, 10'h004));
        vecs.push_back(mk("jmp_if", 7'b0_1_1_0_0_0_1, 10'h010, 10'h030, 10'h020, 10'h010, 10'h2AF, 10'h005));
        vecs.push_back(mk("jmp_m",  7'b0_1_1_0_0_1_1, 10'h010, 10'h030, 10'h020, 10'h020, 10'h2BA, 10'h010));
        vecs.push_back(mk("jmp_ex", 7'b0_1_1_0_1_1_1, 10'h010, 10'h030, 10'h020, 10'h030, 10'h28A, 10'h020));
        vecs.push_back(mk("to7",    7'b0_1_1_0_0_0_1, 10'h007, 10'h000, 10'h000, 10'h007, 10'h29A, 10'h030));
        vecs.push_back(mk("to8",    7'b0_0_1_0_0_0_1, 10'h000, 10'h000, 10'h000, 10'h008, 10'h2AD, 10'h007));
        vecs.push_back(mk("replay", 7'b0_0_1_1_0_0_1, 10'h000, 10'h000, 10'h000, 10'h007, 10'h2A2, 10'h008));
        vecs.push_back(mk("hz_jmp", 7'b0_1_1_1_0_0_1, 10'h100, 10'h000, 10'h000, 10'h100, 10'h2AD, 10'h007));
        vecs.push_back(mk("stall1", 7'b0_0_0_0_0_0_1, 10'h000, 10'h000, 10'h000, 10'h100, 10'h3AA, 10'h100));
        vecs.push_back(mk("stall2", 7'b0_0_0_0_0_0_1, 10'h000, 10'h000, 10'h000, 10'h100, 10'h3AA, 10'h100));
        vecs.push_back(mk("stall3", 7'b0_0_0_0_0_0_1, 10'h000, 10'h000, 10'h000, 10'h100, 10'h3AA, 10'h100));
        vecs.push_back(mk("nocr1",  7'b0_0_1_0_0_0_0, 10'h000, 10'h000, 10'h000, 10'h101, 10'h3AA, 10'h100));
        vecs.push_back(mk("nocr2",  7'b0_0_1_0_0_0_0, 10'h000, 10'h000, 10'h000, 10'h102, 10'h3AA, 10'h100));
        vecs.push_back(mk("cr_up",  7'b0_0_1_0_0_0_1, 10'h000, 10'h000, 10'h000, 10'h103, 10'h3A8, 10'h102));
        vecs.push_back(mk("to3ff",  7'b0_1_1_0_0_0_1, 10'h3FF, 10'h000, 10'h000, 10'h3FF, 10'h3A9, 10'h103));
        vecs.push_back(mk("wrap",   7'b0_0_1_0_0_0_1, 10'h000, 10'h000, 10'h000, 10'h000, 10'h155, 10'h3FF));
        vecs.push_back(mk("post_w", 7'b0_0_1_0_0_0_1, 10'h000, 10'h000, 10'h000, 10'h001, 10'h2AA, 10'h000));
        vecs.push_back(mk("to55",   7'b0_1_1_0_0_0_1, 10'h055, 10'h000, 10'h000, 10'h055, 10'h2AB, 10'h001));
        vecs.push_back(mk("rst_mid",7'b1_1_0_1_1_0_1, 10'h123, 10'h234, 10'h345, 10'h000, 10'h000, 10'h000));
        vecs.push_back(mk("post_r", 7'b0_0_1_0_0_0_1, 10'h000, 10'h000, 10'h000, 10'h001, 10'h2AA, 10'h000));

        foreach (vecs[i])
            step_chk(vecs[i].name, vecs[i].ctl, vecs[i].la_if, vecs[i].la_ex, vecs[i].la_m,
                     vecs[i].exp_addr, vecs[i].exp_ins, vecs[i].exp_pc);

        // Full stall: both enables low, nothing moves; imem_addr also
        // sampled mid-cycle to confirm it tracks the held register.
        drive(7'b0_1_0_0_1_0_0, 10'h3C3, 10'h2C0, 10'h3C0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("fstall.mid", imem_addr, 10'h001);
            @(posedge clk);
            #1;
            chk("fstall.addr", imem_addr, 10'h001);
            chk("fstall.ins",  instruction_out, 10'h2AA);
            chk("fstall.pc",   pc_out, 10'h000);
        end

        // EX target alone (F=0) once the stall releases.
        step_chk("jmp_ex_only", 7'b0_1_1_0_1_0_1, 10'h3C3, 10'h2C0, 10'h3C0,
                 10'h2C0, 10'h2AB, 10'h001);
        // Replay with capture disabled: pc_out still 001, so pc returns there.
        step_chk("hz_nocr", 7'b0_0_1_1_0_0_0, 10'h000, 10'h000, 10'h000,
                 10'h001, 10'h2AB, 10'h001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 10-bit pipelined CPU.
- Holds the program counter (PC), selects the next PC and drives the instruction-memory address.
- Next-PC sources: sequential increment, replay of the fetched PC, or a jump/branch target from the IF, EX or M stage.
- Latches the fetched instruction and its PC into the IF/ID pipeline register for decode.
- Instruction memory is external; its read is combinational.

Parameters:
- W, 10, datapath, PC and instruction width.
- RESET_PC, 10'h000, PC and IF-register value after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- j_cntrl  input  1  1 = next PC comes from the selected jump target.
- pc_en  input  1  1 = PC register loads next PC; 0 = PC holds.
- pc_hazard  input  1  1 = sequential path replays the IF-register PC instead of PC+1.
- E  input  1  1 = jump target from EX stage (LA_EX); highest priority.
- F  input  1  1 = jump target from M stage (LA_M) when E=0.
- cache_Ready  input  1  1 = IF register captures the fetched instruction and PC.
- LA_IF  input  W  jump target computed in IF/decode.
- LA_EX  input  W  jump target from EX.
- LA_M  input  W  jump target from M.
- imem_rdata  input  W  instruction word at imem_addr (combinational).
- imem_addr  output  W  current PC register value.
- instruction_out  output  W  IF-register instruction.
- pc_out  output  W  IF-register PC.

Behaviour:
- Target select: la = E ? LA_EX : (F ? LA_M : LA_IF). E wins when E=F=1.
- Sequential select: seq = pc_hazard ? pc_out : (pc + 1).
- Next PC: next = j_cntrl ? la : seq. j_cntrl overrides pc_hazard.
- Incrementer: W-bit add of pc and 1 with carry-in 0. Carry-out is discarded, so 10'h3FF wraps to 10'h000.
- PC register, on posedge clk:
  - reset=1: pc <= RESET_PC, regardless of pc_en.
  - else if pc_en=1: pc <= next.
  - else: pc holds.
- imem_addr = pc, combinationally.
- IF register, on posedge clk:
  - reset=1: instruction_out <= 0 and pc_out <= RESET_PC.
  - else if cache_Ready=1: instruction_out <= imem_rdata and pc_out <= pc (pre-edge value).
  - else: both hold.
- Latency: the instruction at address A appears on instruction_out one edge after pc==A, provided cache_Ready=1.
- cache_Ready and pc_en are independent. Stalling the whole stage requires the controller to drop both.
- Reset mid-operation: both registers return to reset values on the next edge. All other inputs are ignored during that edge.
- No X propagation required; inputs are assumed driven. All outputs are registered except imem_addr, which is the register value.

Decomposition:
- Shared package cpu_pkg: constant W=10, RESET_PC, word typedef logic [W-1:0].
- One natural sub-module: pc_incrementer, a W-bit adder with cin/cout, instantiated with B=1, cin=0.
- The 2:1 muxes, PC register and IF register stay inline in fetch_stage.

Test Plan:
- The bench memory model returns imem_rdata = imem_addr ^ 10'h2AA.
- Reset: assert reset 1 cycle with pc_en=1, cache_Ready=1 -> pc=0, instruction_out=0, pc_out=0. Then deassert with j_cntrl=0, pc_hazard=0 -> imem_addr 1,2,3 on successive edges; pc_out lags one edge (0,1,2); instruction_out=pc_out^2AA.
- Jump priority: pc=5, j_cntrl=1, LA_IF=10'h010, LA_M=10'h020, LA_EX=10'h030:
  - E=0,F=0 -> pc=10'h010.
  - F=1 -> 10'h020.
  - E=1,F=1 -> 10'h030.
- Replay: pc_out=10'h007, pc=10'h008, pc_hazard=1, j_cntrl=0 -> pc becomes 10'h007; with pc_hazard=1 and j_cntrl=1, LA_IF=10'h100 -> pc=10'h100.
- Stalls:
  - pc_en=0 for 3 cycles -> imem_addr constant.
  - cache_Ready=0 -> instruction_out and pc_out hold while pc still advances.
  - Re-raising cache_Ready -> capture resumes on the next edge.
- Wrap: jump to 10'h3FF, then sequential -> next pc=10'h000, no glitch on pc_out.
- Reset mid-run: at pc=10'h055 with cache_Ready=1 and pc_en=0, assert reset -> all outputs zero after one edge; imem_addr=0.
